shift_reg_seq: RTL and testbench
================================

# shift_reg_seq

Parametrised multi-cycle shift register that generalises the fixed 17-bit load/select register into a WIDTH-bit datapath register. It supports parallel load, clear, and shifts/rotates by a programmable amount, one bit position per clock, with a start/busy/done handshake. It is the operand/accumulator register for the sequential multiplier and divider datapaths, which issue shift commands and wait on `done`.

## Interface
- `WIDTH`, 17, data width in bits (≥2).
- `AMT_W`, 5, width of shift-amount port.
- `RST_VAL`, 0, value of `out` after reset.

- `clk`, in, 1, single clock; all state updates on rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `in`, in, WIDTH, parallel load data.
- `load`, in, 1, parallel load request.
- `sel`, in, 3, operation for `start`.
- `amt`, in, AMT_W, shift count for `start`.
- `start`, in, 1, begin operation.
- `sin`, in, 1, serial input bit for sel 5/6.
- `out`, out, WIDTH, register contents.
- `busy`, out, 1, shift in progress.
- `done`, out, 1, one-cycle completion pulse.
- `cout`, out, 1, last bit shifted/rotated out.

## Operation
- States: IDLE, SHIFT, DONE. Reset state: IDLE, `out`=RST_VAL, `busy`=0, `done`=0, `cout`=0, internal counter=0.
- `sel` encoding: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5 SLI (shift left, LSB←`sin`), 6 SRI (shift right, MSB←`sin`), 7 CLR.
- Commands are accepted only in IDLE or DONE. In SHIFT, `load` and `start` are ignored.
- `load`=1 when accepted: `out`←`in` at that edge; state→IDLE. `load` has priority over `start`; a simultaneous `start` is dropped.
- `start` with sel=7: `out`←0 at that edge; state→DONE.
- `start` with sel 0–6 and `amt`=0: no data change; state→DONE.
- `start` with sel 0–6 and `amt`>0: latch `sel` and `amt`; state→SHIFT. Each SHIFT cycle applies one 1-bit step of the latched op and decrements the counter. When the counter reaches 0 after a step, state→DONE.
- `amt`≥WIDTH is legal and is executed literally. SLL/SRL saturate to 0, SRA saturates to sign fill, and rotates wrap.
- `sin` is sampled on every step, so it may change per cycle.
- DONE lasts exactly one cycle, then returns to IDLE unless a new command is accepted.

## Timing
- `busy`=1 exactly while state=SHIFT. `done`=1 exactly while state=DONE. Both are registered outputs.
- `start` sampled at edge E0 with `amt`=N>0:
  - `busy` high after E0.
  - Steps occur at edges E1..EN.
  - After EN, `busy`=0 and `done`=1.
  - Total latency: N+1 edges from start to done.
- `amt`=0 or CLR: `done` is high after E0, i.e. 1-edge latency.
- `load` result is visible in `out` one edge after sampling. `done` is not asserted for a load.
- Asserting `rst` at any time, including mid-SHIFT, forces IDLE and RST_VAL immediately. Partial shifts are discarded.

## Configuration
- `SHIFT_REG_SEQ_CARRY_EN` defined:
  - `cout` is updated on every shift/rotate step with the bit leaving the register (MSB for left ops, LSB for right ops).
  - `cout` is cleared by CLR and by reset.
  - `cout` is held otherwise, including during load.
- `SHIFT_REG_SEQ_CARRY_EN` not defined: the `cout` port remains and is tied to 0. No carry flop is synthesised.

## Structure
- Package `shift_reg_seq_pkg` contains:
  - the `sel` opcode enum (SEL_SLL … SEL_CLR, 3 bits);
  - the state enum (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module `shift_step`: combinational one-bit shift/rotate unit.
  - Parameter: WIDTH.
  - Inputs: data, op, sin.
  - Outputs: next data, bit out.
  - The top level is instantiated once.
- Top level contains the FSM, the down-counter, the data register and the carry flop.

## Test plan
- All scenarios use WIDTH=17 with the macro defined.
- Load, then SLL by 3: load 17'h00002, then start sel=0 amt=3 → `busy` high for 3 cycles; `out`=17'h00010; `done` pulses exactly 4 edges after start; `cout`=0.
- SRA by 4: `out`=17'h10000, start sel=2 amt=4 → `out`=17'h1F000, `cout`=0.
- ROR by 1: `out`=17'h00001, start sel=4 amt=1 → `out`=17'h10000, `cout`=1. Rerun without the macro → `cout` stays 0.
- Reset mid-shift: start sel=1 amt=10 on 17'h1FFFF; assert `rst` on the 4th SHIFT cycle → `out`=0, `busy`=0 and `done`=0 immediately, with no later `done`.
- Load with simultaneous start, and commands during busy: `load`=1 with `start`=1 → `out`=`in` and no `busy`. Then start SLL amt=5 and pulse `load` while busy → the load is ignored and the shift completes unchanged.
- Edge amounts: `amt`=0 → `done` the next edge with `out` unchanged. SLL `amt`=20 on 17'h1FFFF → `out`=0 after 20 steps. CLR → `out`=0 and `done` after 1 edge.

Source files
------------

// File: rtl/shift_reg_seq_pkg.sv
// Opcode and state encodings shared by the sequential shift register and its step unit.
package shift_reg_seq_pkg;

  typedef enum logic [2:0] {
    SEL_SLL = 3'd0,
    SEL_SRL = 3'd1,
    SEL_SRA = 3'd2,
    SEL_ROL = 3'd3,
    SEL_ROR = 3'd4,
    SEL_SLI = 3'd5,
    SEL_SRI = 3'd6,
    SEL_CLR = 3'd7
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_reg_seq_if.sv
// Command/result bundle of shift_reg_seq; master issues load/start, slave owns the register.
interface shift_reg_seq_if #(
  parameter int WIDTH = 17,
  parameter int AMT_W = 5
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       sel;
  logic [AMT_W-1:0] amt;
  logic             start;
  logic             sin;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             cout;

  modport master (
    output in, load, sel, amt, start, sin,
    input  out, busy, done, cout
  );

  modport slave (
    input  in, load, sel, amt, start, sin,
    output out, busy, done, cout
  );
endinterface

// File: rtl/shift_reg_seq_shift_step.sv
// One-bit shift/rotate unit, purely combinational (zero latency, no flow control).
module shift_step
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] data,
  input  sel_e             op,
  input  logic             sin,
  output logic [WIDTH-1:0] next_data,
  output logic             bit_out
);

  always_comb begin
    next_data = data;
    bit_out   = 1'b0;
    case (op)
      SEL_SLL: begin next_data = {data[WIDTH-2:0], 1'b0};           bit_out = data[WIDTH-1]; end
      SEL_SRL: begin next_data = {1'b0, data[WIDTH-1:1]};           bit_out = data[0];       end
      SEL_SRA: begin next_data = {data[WIDTH-1], data[WIDTH-1:1]};  bit_out = data[0];       end
      SEL_ROL: begin next_data = {data[WIDTH-2:0], data[WIDTH-1]};  bit_out = data[WIDTH-1]; end
      SEL_ROR: begin next_data = {data[0], data[WIDTH-1:1]};        bit_out = data[0];       end
      SEL_SLI: begin next_data = {data[WIDTH-2:0], sin};            bit_out = data[WIDTH-1]; end
      SEL_SRI: begin next_data = {sin, data[WIDTH-1:1]};            bit_out = data[0];       end
      default: begin next_data = '0;                                bit_out = 1'b0;          end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// WIDTH-bit register with load/clear and multi-cycle shifts, one bit per clock; N+1 edges start->done.
// Commands are ignored while busy; define SHIFT_REG_SEQ_CARRY_EN to keep a carry-out flop.
module shift_reg_seq
  import shift_reg_seq_pkg::*;
#(
  parameter int               WIDTH   = 17,
  parameter int               AMT_W   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  shift_reg_seq_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  sel_e             op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_dat;
  logic             step_bo;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data      (data_q),
    .op        (op_q),
    .sin       (bus.sin),
    .next_data (step_dat),
    .bit_out   (step_bo)
  );

`ifdef SHIFT_REG_SEQ_CARRY_EN
  logic cout_q, cout_d;
`else
  logic unused_step_bo;
  assign unused_step_bo = step_bo;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef SHIFT_REG_SEQ_CARRY_EN
    cout_d  = cout_q;
`endif
    if (state_q == ST_SHIFT) begin
      data_d = step_dat;
      cnt_d  = cnt_q - AMT_W'(1);
`ifdef SHIFT_REG_SEQ_CARRY_EN
      cout_d = step_bo;
`endif
      if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
    end else begin
      // IDLE and DONE both accept commands; load wins over start
      state_d = ST_IDLE;
      if (bus.load) begin
        data_d = bus.in;
      end else if (bus.start) begin
        if (sel_e'(bus.sel) == SEL_CLR) begin
          data_d  = '0;
          state_d = ST_DONE;
`ifdef SHIFT_REG_SEQ_CARRY_EN
          cout_d  = 1'b0;
`endif
        end else if (bus.amt == '0) begin
          state_d = ST_DONE;
        end else begin
          op_d    = sel_e'(bus.sel);
          cnt_d   = bus.amt;
          state_d = ST_SHIFT;
        end
      end
    end
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= RST_VAL;
      cnt_q   <= '0;
      op_q    <= SEL_SLL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_REG_SEQ_CARRY_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SHIFT_REG_SEQ_CARRY_EN
      cout_q  <= cout_d;
`endif
    end
  end

  assign bus.out  = data_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef SHIFT_REG_SEQ_CARRY_EN
  assign bus.cout = cout_q;
`else
  assign bus.cout = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed vector table, hand-written corner sequences, random commands vs. arithmetic model.
module tb_shift_reg_seq;
  localparam int W  = 17;
  localparam int AW = 5;
  localparam int BUDGET = 64;
  localparam int unsigned HALF = 32'd1 << (W - 1);
  localparam int unsigned FULL = 32'd1 << W;
  localparam bit CARRY_EN =
`ifdef SHIFT_REG_SEQ_CARRY_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_reg_seq_if #(.WIDTH(W), .AMT_W(AW)) bus();

  shift_reg_seq #(.WIDTH(W), .AMT_W(AW), .RST_VAL(17'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_out;
  logic         m_cout;
  logic         sin_q[$];

  typedef struct {
    logic         load;
    logic         start;
    logic [2:0]   sel;
    logic [AW-1:0] amt;
    logic [W-1:0] din;
    logic         sin;
    logic [W-1:0] exp_out;
    logic         exp_cout;
    int           exp_cyc;
  } vec_t;

  vec_t vec[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference step written as integer arithmetic on the register value
  task automatic mstep(input int op, input logic [W-1:0] v, input logic s,
                       output logic [W-1:0] nv, output logic bo);
    int unsigned x;
    int unsigned msb;
    x   = 32'(v);
    msb = (x >= HALF) ? 32'd1 : 32'd0;
    case (op)
      0: begin bo = msb[0]; nv = W'((x * 2) % FULL); end
      1: begin bo = x[0];   nv = W'(x / 2); end
      2: begin bo = x[0];   nv = W'(x / 2 + msb * HALF); end
      3: begin bo = msb[0]; nv = W'((x * 2) % FULL + msb); end
      4: begin bo = x[0];   nv = W'(x / 2 + (x % 2) * HALF); end
      5: begin bo = msb[0]; nv = W'((x * 2) % FULL + 32'(s)); end
      6: begin bo = x[0];   nv = W'(x / 2 + 32'(s) * HALF); end
      default: begin bo = 1'b0; nv = '0; end
    endcase
  endtask

  task automatic idle_inputs();
    bus.load  = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int nb;
    bus.load = v.load; bus.start = v.start; bus.sel = v.sel;
    bus.amt  = v.amt;  bus.in    = v.din;   bus.sin = v.sin;
    tick();
    idle_inputs();
    if (v.exp_cyc == 0) begin
      chk($sformatf("vec%0d_load_out", idx), 32'(bus.out), 32'(v.exp_out));
      chk($sformatf("vec%0d_load_nodone", idx), {31'd0, bus.done | bus.busy}, 32'd0);
    end else begin
      cyc = 1; nb = 0;
      while (!bus.done && cyc < BUDGET) begin
        if (bus.busy) nb++;
        tick();
        cyc++;
      end
      chk($sformatf("vec%0d_latency", idx), 32'(cyc), 32'(v.exp_cyc));
      chk($sformatf("vec%0d_busy_cycles", idx), 32'(nb), 32'(v.exp_cyc - 1));
      tick();
      chk($sformatf("vec%0d_done_pulse", idx), {31'd0, bus.done}, 32'd0);
    end
    chk($sformatf("vec%0d_out", idx), 32'(bus.out), 32'(v.exp_out));
    chk($sformatf("vec%0d_cout", idx), {31'd0, bus.cout}, {31'd0, v.exp_cout & CARRY_EN});
  endtask

  task automatic rand_cmd(input int idx);
    int sel;
    int amt;
    int cyc;
    int exp_cyc;
    logic s;
    logic [W-1:0] din;
    logic [W-1:0] v;
    logic [W-1:0] nv;
    logic bo;
    if ($urandom_range(0, 3) == 0) begin
      din = W'($urandom);
      bus.in = din; bus.load = 1'b1; bus.start = 1'($urandom_range(0, 1));
      bus.sel = 3'($urandom); bus.amt = AW'($urandom);
      tick();
      idle_inputs();
      m_out = din;
      chk($sformatf("rnd%0d_load_out", idx), 32'(bus.out), 32'(m_out));
      chk($sformatf("rnd%0d_load_busy", idx), {31'd0, bus.busy | bus.done}, 32'd0);
    end else begin
      sel = $urandom_range(0, 7);
      amt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
      bus.sel = 3'(sel); bus.amt = AW'(amt); bus.start = 1'b1; bus.sin = 1'($urandom);
      tick();
      idle_inputs();
      sin_q.delete();
      cyc = 1;
      while (!bus.done && cyc < BUDGET) begin
        if (bus.busy) begin
          s = 1'($urandom);
          bus.sin = s;
          sin_q.push_back(s);
          bus.load  = 1'($urandom);
          bus.start = 1'($urandom);
          bus.in    = W'($urandom);
        end
        tick();
        cyc++;
      end
      idle_inputs();
      if (sel == 7) begin
        m_out = '0; m_cout = 1'b0; exp_cyc = 1;
      end else begin
        v = m_out;
        for (int k = 0; k < amt; k++) begin
          s = (k < sin_q.size()) ? sin_q[k] : 1'b0;
          mstep(sel, v, s, nv, bo);
          v = nv;
          m_cout = bo;
        end
        m_out = v;
        exp_cyc = (amt == 0) ? 1 : amt + 1;
      end
      chk($sformatf("rnd%0d_latency", idx), 32'(cyc), 32'(exp_cyc));
      chk($sformatf("rnd%0d_out", idx), 32'(bus.out), 32'(m_out));
    end
    chk($sformatf("rnd%0d_cout", idx), {31'd0, bus.cout}, {31'd0, m_cout & CARRY_EN});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit saw_done;

    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h00002, 1'b0, 17'h00002, 1'b0, 0});
    vec.push_back('{1'b0, 1'b1, 3'd0, 5'd3,  17'h00000, 1'b0, 17'h00010, 1'b0, 4});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h10000, 1'b0, 17'h10000, 1'b0, 0});
    vec.push_back('{1'b0, 1'b1, 3'd2, 5'd4,  17'h00000, 1'b0, 17'h1F000, 1'b0, 5});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h00001, 1'b0, 17'h00001, 1'b0, 0});
    vec.push_back('{1'b0, 1'b1, 3'd4, 5'd1,  17'h00000, 1'b0, 17'h10000, 1'b1, 2});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h1ABCD, 1'b0, 17'h1ABCD, 1'b1, 0});
    vec.push_back('{1'b0, 1'b1, 3'd7, 5'd9,  17'h00000, 1'b0, 17'h00000, 1'b0, 1});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h1FFFF, 1'b0, 17'h1FFFF, 1'b0, 0});
    vec.push_back('{1'b0, 1'b1, 3'd0, 5'd20, 17'h00000, 1'b0, 17'h00000, 1'b0, 21});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h0ABCD, 1'b0, 17'h0ABCD, 1'b0, 0});
    vec.push_back('{1'b0, 1'b1, 3'd3, 5'd0,  17'h00000, 1'b0, 17'h0ABCD, 1'b0, 1});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h1FFFF, 1'b0, 17'h1FFFF, 1'b0, 0});
    vec.push_back('{1'b0, 1'b1, 3'd1, 5'd17, 17'h00000, 1'b0, 17'h00000, 1'b1, 18});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h12345, 1'b0, 17'h12345, 1'b1, 0});
    vec.push_back('{1'b0, 1'b1, 3'd3, 5'd17, 17'h00000, 1'b0, 17'h12345, 1'b1, 18});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h00000, 1'b0, 17'h00000, 1'b1, 0});
    vec.push_back('{1'b0, 1'b1, 3'd6, 5'd3,  17'h00000, 1'b1, 17'h1C000, 1'b0, 4});
    vec.push_back('{1'b1, 1'b0, 3'd0, 5'd0,  17'h00003, 1'b0, 17'h00003, 1'b0, 0});
    vec.push_back('{1'b0, 1'b1, 3'd5, 5'd2,  17'h00000, 1'b1, 17'h0000F, 1'b0, 3});

    rst = 1'b1;
    bus.in = '0; bus.load = 1'b0; bus.sel = '0; bus.amt = '0; bus.start = 1'b0; bus.sin = 1'b0;
    tick();
    tick();
    chk("reset_out",  32'(bus.out), 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_cout", {31'd0, bus.cout}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < vec.size(); i++) run_vec(vec[i], i);

    // load and start together: load wins, nothing starts
    bus.load = 1'b1; bus.start = 1'b1; bus.sel = 3'd0; bus.amt = 5'd3; bus.in = 17'h05555;
    tick();
    idle_inputs();
    chk("ldst_out", 32'(bus.out), 32'h05555);
    chk("ldst_busy", {31'd0, bus.busy | bus.done}, 32'd0);
    tick();
    chk("ldst_busy_later", {31'd0, bus.busy | bus.done}, 32'd0);

    // load pulsed mid-shift must be ignored
    bus.start = 1'b1; bus.sel = 3'd0; bus.amt = 5'd5;
    tick();
    bus.start = 1'b0;
    chk("busyld_busy", {31'd0, bus.busy}, 32'd1);
    bus.load = 1'b1; bus.in = 17'h1FFFF;
    tick();
    bus.load = 1'b0;
    cyc = 2;
    while (!bus.done && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    chk("busyld_latency", 32'(cyc), 32'd6);
    chk("busyld_out", 32'(bus.out), 32'h0AAA0);
    chk("busyld_cout", {31'd0, bus.cout}, {31'd0, CARRY_EN});

    // reset during the 4th SHIFT cycle of an SRL by 10
    bus.load = 1'b1; bus.in = 17'h1FFFF;
    tick();
    bus.load = 1'b0;
    bus.start = 1'b1; bus.sel = 3'd1; bus.amt = 5'd10;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("midrst_pre_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out",  32'(bus.out), 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_cout", {31'd0, bus.cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, saw_done}, 32'd0);

    m_out = '0;
    m_cout = 1'b0;
    for (int i = 0; i < 250; i++) rand_cmd(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
